// File: rtl/dualmem_pkg.sv
// Shared types and helpers for the dualmem true-dual-port RAM family.
package dualmem_pkg;

    // Top-level sequencer states: INIT clears the array, READY serves requests.
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned BYTE_W = 8;

    // Byte-lane merge: take the new byte where its enable is set, else keep the old one.
    function automatic logic [BYTE_W-1:0] be_merge(input logic [BYTE_W-1:0] old_byte,
                                                   input logic [BYTE_W-1:0] wdata_byte,
                                                   input logic              be);
        return be ? wdata_byte : old_byte;
    endfunction

endpackage

// File: rtl/dualmem_tdp_array.sv
// Bare inferrable true-dual-port byte-write RAM. Read-first, no reset on storage.
// Read data only updates on a read access so the caller can rely on it being held.
module dualmem_tdp_array #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    a_en_i,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    input  logic                    b_en_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic [DATA_WIDTH-1:0]   b_rdata_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Both ports in one process; A's byte writes come last so A wins a same-byte overlap.
    always_ff @(posedge clk_i) begin
        if (a_en_i && !a_we_i) begin
            a_rdata_o <= mem[a_addr_i];
        end
        if (b_en_i && !b_we_i) begin
            b_rdata_o <= mem[b_addr_i];
        end
        if (b_en_i && b_we_i) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (b_be_i[i]) begin
                    mem[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
                end
            end
        end
        if (a_en_i && a_we_i) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (a_be_i[i]) begin
                    mem[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dualmem_tdp_pipe.sv
// True-dual-port byte-writable RAM with req/gnt/rvalid handshake, post-reset clear,
// deterministic same-address collision handling and an optional output register.
module dualmem_tdp_pipe
    import dualmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned DEPTH          = 512,
    parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    a_req_i,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    output logic                    a_gnt_o,
    output logic                    a_rvalid_o,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    input  logic                    b_req_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic                    b_gnt_o,
    output logic                    b_rvalid_o,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,
    output logic                    init_done_o,
    output logic                    collision_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // ---------------------------------------------------------------- INIT sequencer
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ready;
    logic                  clearing;

    // State and clear-address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: walk the clear counter to the last word, or skip straight to READY.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            INIT: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_d = READY;
                end else if (clr_cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign ready       = (state_q == READY);
    assign clearing    = (state_q == INIT) && (CLEAR_ON_RESET != 0);
    assign init_done_o = ready;

    // ---------------------------------------------------------------- request decode
    logic                  a_ok, b_ok, same_addr;
    logic                  a_wr, b_wr, a_rd, b_rd;
    logic [NB-1:0]         b_be_eff;

    assign a_gnt_o   = a_req_i & ready;
    assign b_gnt_o   = b_req_i & ready;
    assign a_ok      = 32'(a_addr_i) < DEPTH;
    assign b_ok      = 32'(b_addr_i) < DEPTH;
    assign same_addr = (a_addr_i == b_addr_i);
    assign a_wr      = a_gnt_o & a_we_i & a_ok;
    assign b_wr      = b_gnt_o & b_we_i & b_ok;
    assign a_rd      = a_gnt_o & ~a_we_i;
    assign b_rd      = b_gnt_o & ~b_we_i;

    // On a same-address double write, B only lands in bytes A leaves untouched.
    assign b_be_eff  = b_be_i & ~((a_wr && same_addr) ? a_be_i : '0);

    // ---------------------------------------------------------------- array ports
    logic                  arr_a_en, arr_a_we, arr_b_en;
    logic [NB-1:0]         arr_a_be;
    logic [ADDR_WIDTH-1:0] arr_a_addr;
    logic [DATA_WIDTH-1:0] arr_a_wdata, arr_a_rdata, arr_b_rdata;

    // Port A is borrowed by the clear sequencer while INIT is zero-filling.
    always_comb begin
        arr_a_en    = a_wr | (a_rd & a_ok);
        arr_a_we    = a_wr;
        arr_a_be    = a_be_i;
        arr_a_addr  = a_addr_i;
        arr_a_wdata = a_wdata_i;
        if (clearing) begin
            arr_a_en    = 1'b1;
            arr_a_we    = 1'b1;
            arr_a_be    = '1;
            arr_a_addr  = clr_cnt_q;
            arr_a_wdata = '0;
        end
    end

    assign arr_b_en = b_wr | (b_rd & b_ok);

    dualmem_tdp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i     (clk_i),
        .a_en_i    (arr_a_en),
        .a_we_i    (arr_a_we),
        .a_be_i    (arr_a_be),
        .a_addr_i  (arr_a_addr),
        .a_wdata_i (arr_a_wdata),
        .a_rdata_o (arr_a_rdata),
        .b_en_i    (arr_b_en),
        .b_we_i    (b_wr),
        .b_be_i    (b_be_eff),
        .b_addr_i  (b_addr_i),
        .b_wdata_i (b_wdata_i),
        .b_rdata_o (arr_b_rdata)
    );

    // ---------------------------------------------------------------- read pipeline
    // zero_q resets high so the read word is 0 until the first real read lands.
    logic                  a_rd_q, b_rd_q, a_zero_q, b_zero_q, collision_q;
    logic [NB-1:0]         a_fbe_q, b_fbe_q;
    logic [DATA_WIDTH-1:0] a_fwd_q, b_fwd_q, a_word, b_word;

    // Capture per-read side info: out-of-range flag and the other port's same-cycle write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rd_q      <= 1'b0;
            b_rd_q      <= 1'b0;
            a_zero_q    <= 1'b1;
            b_zero_q    <= 1'b1;
            a_fbe_q     <= '0;
            b_fbe_q     <= '0;
            a_fwd_q     <= '0;
            b_fwd_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            a_rd_q      <= a_rd;
            b_rd_q      <= b_rd;
            collision_q <= a_gnt_o & b_gnt_o & a_we_i & b_we_i & same_addr &
                           (|(a_be_i & b_be_i));
            if (a_rd) begin
                a_zero_q <= ~a_ok;
                a_fbe_q  <= (b_wr && same_addr) ? b_be_eff : '0;
                a_fwd_q  <= b_wdata_i;
            end
            if (b_rd) begin
                b_zero_q <= ~b_ok;
                b_fbe_q  <= (a_wr && same_addr) ? a_be_i : '0;
                b_fwd_q  <= a_wdata_i;
            end
        end
    end

    assign collision_o = collision_q;

    // Write-first view: overlay the forwarded bytes on the read-first array output.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            a_word[i*8 +: 8] = a_zero_q ? 8'h00 :
                               be_merge(arr_a_rdata[i*8 +: 8], a_fwd_q[i*8 +: 8], a_fbe_q[i]);
            b_word[i*8 +: 8] = b_zero_q ? 8'h00 :
                               be_merge(arr_b_rdata[i*8 +: 8], b_fwd_q[i*8 +: 8], b_fbe_q[i]);
        end
    end

    // ---------------------------------------------------------------- output stage
    if (OUT_REG != 0) begin : g_oreg
        logic                  a_rv2_q, b_rv2_q;
        logic [DATA_WIDTH-1:0] a_rd2_q, b_rd2_q;

        // Extra register stage; data only moves when a read completes.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a_rv2_q <= 1'b0;
                b_rv2_q <= 1'b0;
                a_rd2_q <= '0;
                b_rd2_q <= '0;
            end else begin
                a_rv2_q <= a_rd_q;
                b_rv2_q <= b_rd_q;
                if (a_rd_q) begin
                    a_rd2_q <= a_word;
                end
                if (b_rd_q) begin
                    b_rd2_q <= b_word;
                end
            end
        end

        assign a_rvalid_o = a_rv2_q;
        assign b_rvalid_o = b_rv2_q;
        assign a_rdata_o  = a_rd2_q;
        assign b_rdata_o  = b_rd2_q;
    end else begin : g_no_oreg
        assign a_rvalid_o = a_rd_q;
        assign b_rvalid_o = b_rd_q;
        assign a_rdata_o  = a_word;
        assign b_rdata_o  = b_word;
    end

endmodule
